// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Issue stage in front of the 64-bit ALU. Compact operation requests are
// accepted over a valid/ready handshake, decoded into the ALU aluop/cin
// encoding at push time and buffered in a small FIFO. The head entry is
// presented show-ahead to the ALU operand/control inputs with its own
// valid/ready handshake so the ALU consumer can stall without losing work.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake (in_ready from registered state)
//   in_op[2:0]             : 0 AND,1 OR,2 ADD,3 SUB,4 SLT,5 NOR,6 NAND,7 illegal
//   in_a, in_b [W-1:0]     : request operands
//   out_valid/out_ready    : head-entry handshake towards the ALU
//   out_a, out_b [W-1:0]   : head operands (0 when out_valid is low)
//   out_aluop[3:0], out_cin: head decoded control (0 when out_valid is low)
//   count                  : current occupancy
//   err_illegal            : one-cycle pulse after an illegal request is taken
// ---------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_a,
    output logic [W-1:0]               out_b,
    output logic [3:0]                 out_aluop,
    output logic                       out_cin,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);
    localparam logic [2:0]    ILLEGAL_C = 3'd7;

    // Decoded control word {aluop, cin} for a request opcode.
    function automatic logic [4:0] decode_op(input logic [2:0] op);
        logic [4:0] res;
        case (op)
            3'd0:    res = {4'b0000, 1'b0};  // AND
            3'd1:    res = {4'b0001, 1'b0};  // OR
            3'd2:    res = {4'b0010, 1'b0};  // ADD
            3'd3:    res = {4'b0110, 1'b1};  // SUB: b inverted, carry-in 1
            3'd4:    res = {4'b0111, 1'b1};  // SLT: subtract then take sign
            3'd5:    res = {4'b1100, 1'b0};  // NOR
            3'd6:    res = {4'b1101, 1'b0};  // NAND
            default: res = {4'b0000, 1'b0};  // illegal never gets stored
        endcase
        return res;
    endfunction

    logic [W-1:0]  a_mem_r     [DEPTH];
    logic [W-1:0]  b_mem_r     [DEPTH];
    logic [3:0]    aluop_mem_r [DEPTH];
    logic          cin_mem_r   [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic          err_r;

    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          illegal_s;
    logic [4:0]    dec_s;

    // Handshake qualifiers; in_ready deliberately ignores out_ready so a
    // full queue refuses a push even when a pop happens on the same edge.
    always_comb begin
        in_ready  = (count_r != FULL_C);
        out_valid = (count_r != {CW{1'b0}});
        accept_s  = in_valid && in_ready;
        illegal_s = accept_s && (in_op == ILLEGAL_C);
        push_s    = accept_s && (in_op != ILLEGAL_C);
        pop_s     = out_valid && out_ready;
        dec_s     = decode_op(in_op);
    end

    // Storage write port: decoded entry lands at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem_r[i]     <= {W{1'b0}};
                b_mem_r[i]     <= {W{1'b0}};
                aluop_mem_r[i] <= 4'b0000;
                cin_mem_r[i]   <= 1'b0;
            end
        end else if (push_s) begin
            a_mem_r[wptr_r]     <= in_a;
            b_mem_r[wptr_r]     <= in_b;
            aluop_mem_r[wptr_r] <= dec_s[4:1];
            cin_mem_r[wptr_r]   <= dec_s[0];
        end else begin
            a_mem_r[wptr_r]     <= a_mem_r[wptr_r];
        end
    end

    // Pointers, occupancy and the registered illegal-request pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            err_r <= illegal_s;
            if (push_s) begin
                wptr_r <= wptr_r + PONE_C;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PONE_C;
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Show-ahead head view, forced to zero while the queue is empty.
    always_comb begin
        if (out_valid) begin
            out_a     = a_mem_r[rptr_r];
            out_b     = b_mem_r[rptr_r];
            out_aluop = aluop_mem_r[rptr_r];
            out_cin   = cin_mem_r[rptr_r];
        end else begin
            out_a     = {W{1'b0}};
            out_b     = {W{1'b0}};
            out_aluop = 4'b0000;
            out_cin   = 1'b0;
        end
    end

    assign count       = count_r;
    assign err_illegal = err_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

    localparam int W     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [3:0]    out_aluop;
    logic          out_cin;
    logic [2:0]    count;
    logic          err_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_aluop   (out_aluop),
        .out_cin     (out_cin),
        .count       (count),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {aluop, cin} per opcode 0..6.
    logic [4:0] dec_tab [7];

    initial begin
        dec_tab[0] = {4'b0000, 1'b0};
        dec_tab[1] = {4'b0001, 1'b0};
        dec_tab[2] = {4'b0010, 1'b0};
        dec_tab[3] = {4'b0110, 1'b1};
        dec_tab[4] = {4'b0111, 1'b1};
        dec_tab[5] = {4'b1100, 1'b0};
        dec_tab[6] = {4'b1101, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_a = 64'd0; in_b = 64'd0; out_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("rst_count",     {61'd0, count},     64'd0);
        check_eq("rst_out_a",     out_a,              64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single pass: SUB 0xffff - 0xff
        in_valid = 1'b1; in_op = 3'd3; in_a = 64'hffff; in_b = 64'hff; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("sp_valid", {63'd0, out_valid}, 64'd1);
        check_eq("sp_aluop", {60'd0, out_aluop}, 64'h6);
        check_eq("sp_cin",   {63'd0, out_cin},   64'd1);
        check_eq("sp_a",     out_a,              64'hffff);
        check_eq("sp_b",     out_b,              64'hff);
        step();
        check_eq("sp_drained", {63'd0, out_valid}, 64'd0);
        check_eq("sp_zero_a",  out_a,              64'd0);

        // Decode sweep, back to back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_op = 3'(i); in_a = 64'd0; in_b = 64'd5;
            step();
            check_eq($sformatf("sweep_dec%0d", i), {59'd0, out_aluop, out_cin}, {59'd0, dec_tab[i]});
            check_eq($sformatf("sweep_cnt%0d", i), {61'd0, count}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("sweep_empty", {61'd0, count}, 64'd0);

        // Fill and stall
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = 3'd2; in_a = 64'h10 + 64'(i); in_b = 64'd0;
            step();
            check_eq($sformatf("fill_cnt%0d", i), {61'd0, count}, (i < 4) ? 64'(i + 1) : 64'd4);
        end
        check_eq("fill_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("fill_head",     out_a,             64'h10);

        // Full with simultaneous pop: only the pop happens (in_a still 0x14)
        out_ready = 1'b1;
        step();
        check_eq("fullpop_cnt",   {61'd0, count},    64'd3);
        check_eq("fullpop_ready", {63'd0, in_ready}, 64'd1);
        check_eq("fullpop_head",  out_a,             64'h11);
        step();
        in_valid = 1'b0;
        check_eq("late_push_cnt",  {61'd0, count}, 64'd3);
        check_eq("late_push_head", out_a,          64'h12);
        step();
        check_eq("drain_h13", out_a, 64'h13);
        step();
        check_eq("drain_h14", out_a, 64'h14);
        step();
        check_eq("drain_empty", {61'd0, count}, 64'd0);

        // Illegal op with two entries held
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd2; in_a = 64'h21;
        step();
        in_op = 3'd1; in_a = 64'h22;
        step();
        in_op = 3'd7; in_a = 64'h99;
        step();
        in_valid = 1'b0;
        check_eq("ill_err",   {63'd0, err_illegal}, 64'd1);
        check_eq("ill_cnt",   {61'd0, count},       64'd2);
        check_eq("ill_head",  out_a,                64'h21);
        check_eq("ill_aluop", {60'd0, out_aluop},   64'h2);
        step();
        check_eq("ill_err_low", {63'd0, err_illegal}, 64'd0);
        check_eq("ill_cnt2",    {61'd0, count},       64'd2);

        // Illegal push together with a pop
        out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd7; in_a = 64'h98;
        step();
        in_valid = 1'b0;
        check_eq("illpop_err",  {63'd0, err_illegal}, 64'd1);
        check_eq("illpop_cnt",  {61'd0, count},       64'd1);
        check_eq("illpop_head", out_a,                64'h22);
        check_eq("illpop_op",   {60'd0, out_aluop},   64'h1);
        step();
        check_eq("illpop_empty", {61'd0, count}, 64'd0);

        // Six push/pop pairs, then queue three entries and reset asynchronously
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op = 3'd0; in_a = 64'h40 + 64'(i); out_ready = 1'b1;
            step();
            check_eq($sformatf("wrap_head%0d", i), out_a, 64'h40 + 64'(i));
        end
        out_ready = 1'b0;
        in_a = 64'h50;
        step();
        in_a = 64'h51;
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_cnt",  {61'd0, count}, 64'd3);
        check_eq("pre_rst_head", out_a,          64'h45);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {63'd0, out_valid}, 64'd0);
        check_eq("async_cnt",   {61'd0, count},     64'd0);
        check_eq("async_ready", {63'd0, in_ready},  64'd1);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_op = 3'd0; in_a = 64'h1234567890abcdef; in_b = 64'd7;
        step();
        in_valid = 1'b0;
        check_eq("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check_eq("post_rst_a",     out_a,              64'h1234567890abcdef);
        check_eq("post_rst_cnt",   {61'd0, count},     64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
